// File: rtl/drv_conf_scheduler.sv
// TLC5957 function-control word scheduler: host shadow register, commits applied at slice boundaries.
// Optional DRV_CONF_READBACK_EN adds a registered readback port for the active word.
module drv_conf_scheduler #(
  parameter logic [47:0] DEFAULT_CONF = 48'h0,
  parameter int unsigned APPLY_CYCLES = 70,
  parameter int unsigned SAFE_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        clk_enable,
  input  logic        cfg_wr_valid,
  input  logic [2:0]  cfg_wr_addr,
  input  logic [15:0] cfg_wr_data,
  input  logic        cfg_commit,
  input  logic        column_ready,
`ifdef DRV_CONF_READBACK_EN
  input  logic [2:0]  cfg_rd_addr,
  output logic [15:0] cfg_rd_data,
`endif
  output logic [47:0] serialized_conf,
  output logic        new_configuration_ready,
  output logic        cfg_busy,
  output logic        cfg_done
);

  localparam logic [15:0] ApplyLast = 16'(APPLY_CYCLES - 1);
  localparam logic [15:0] SafeLast  = 16'(SAFE_TIMEOUT - 1);

  typedef enum logic [2:0] {StBoot, StIdle, StWaitSafe, StIssue, StApply} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [47:0] shadow_q, shadow_d;
  logic [47:0] active_q, active_d;
  logic        pending_q, pending_d;
  logic        ncr_q, ncr_d;
  logic        done_q, done_d;
  logic        pend_clr;
  logic [15:0] cnt_inc;

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    shadow_d = shadow_q;
    if (cfg_wr_valid) begin
      case (cfg_wr_addr)
        3'd0:    shadow_d[15:0]  = cfg_wr_data;
        3'd1:    shadow_d[31:16] = cfg_wr_data;
        3'd2:    shadow_d[47:32] = cfg_wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    pend_clr = 1'b0;
    done_d   = 1'b0;
    if (clk_enable) begin
      case (state_q)
        StBoot: state_d = StIssue;
        StIdle: begin
          if (pending_q) begin
            state_d = StWaitSafe;
            cnt_d   = '0;
          end
        end
        StWaitSafe: begin
          // Boundary and timeout together still produce a single issue.
          if (column_ready || (cnt_q == SafeLast)) begin
            active_d = shadow_q;
            pend_clr = 1'b1;
            state_d  = StIssue;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StIssue: begin
          state_d = StApply;
          cnt_d   = '0;
        end
        StApply: begin
          if (cnt_q == ApplyLast) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = pending_q ? StWaitSafe : StIdle;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StBoot;
      endcase
    end
    // A commit landing on the snapshot cycle stays pending for the next issue.
    pending_d = cfg_commit | (pending_q & ~pend_clr);
    ncr_d     = (state_d == StIssue);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StBoot;
      cnt_q     <= '0;
      shadow_q  <= DEFAULT_CONF;
      active_q  <= DEFAULT_CONF;
      pending_q <= 1'b0;
      ncr_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ncr_q     <= ncr_d;
      done_q    <= done_d;
    end
  end

  assign serialized_conf         = active_q;
  assign new_configuration_ready = ncr_q;
  assign cfg_done                = done_q;
  assign cfg_busy                = (state_q != StIdle) | pending_q;

`ifdef DRV_CONF_READBACK_EN
  logic [15:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = 16'h0;
    case (cfg_rd_addr)
      3'd0:    rd_data_d = active_q[15:0];
      3'd1:    rd_data_d = active_q[31:16];
      3'd2:    rd_data_d = active_q[47:32];
      default: rd_data_d = 16'h0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_data_q <= 16'h0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign cfg_rd_data = rd_data_q;
`endif

endmodule
